adder_share_ctrl: RTL and testbench

- Sequencer that time-shares one external 32-bit two-level carry-lookahead adder among NUM_REQ requesters, for example the ALU, the PC incrementer and the branch-target unit.
- Arbitrates round-robin, latches the winner's operands and configures the adder (B inversion and carry-in for subtract).
- Registers sum, carry-out and signed overflow, then returns them on a single tagged response channel with a valid/ready handshake.

---
 rtl/adder_share_pkg.sv | 17 +
 rtl/adder_share_ctrl_rr_pick.sv | 39 +++
 rtl/adder_share_ctrl.sv | 118 +++++++++++
 tb/tb_adder_share_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/adder_share_pkg.sv
// Shared types and helpers for the time-shared adder sequencer.
package adder_share_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Two's-complement overflow: operands agree in sign, result disagrees.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/adder_share_ctrl_rr_pick.sv
// Combinational round-robin selector: first set request after the last winner.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_last,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);

  import adder_share_pkg::*;

  int unsigned w_pos;

  // Search last+1, last+2, ... wrapping; the last winner is checked last.
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    w_pos = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_pos = (32'(i_last) + k) % NUM_REQ;
      if (!o_any && i_req[ID_W'(w_pos)]) begin
        o_any = 1'b1;
        o_idx = ID_W'(w_pos);
      end
    end
  end

  // One-hot form of the chosen index.
  always_comb begin
    o_grant = '0;
    if (o_any) begin
      o_grant = NUM_REQ'(1) << o_idx;
    end
  end

endmodule

// File: rtl/adder_share_ctrl.sv
// Sequencer sharing one external 32-bit adder among NUM_REQ requesters.
module adder_share_ctrl
  import adder_share_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [DATA_W*NUM_REQ-1:0]   req_a,
  input  logic [DATA_W*NUM_REQ-1:0]   req_b,
  input  logic [NUM_REQ-1:0]          req_sub,
  output logic [DATA_W-1:0]           adder_a,
  output logic [DATA_W-1:0]           adder_b,
  output logic                        adder_cin,
  input  logic [DATA_W-1:0]           adder_sum,
  input  logic                        adder_cout,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [ID_W-1:0]             resp_id,
  output logic [DATA_W-1:0]           resp_sum,
  output logic                        resp_cout,
  output logic                        resp_ovf
);

  state_e             r_state;
  logic [ID_W-1:0]    r_last;
  logic [DATA_W-1:0]  r_op_a;
  logic [DATA_W-1:0]  r_op_b;
  logic               r_op_sub;
  logic [ID_W-1:0]    r_id;
  logic [DATA_W-1:0]  r_sum;
  logic               r_cout;
  logic               r_ovf;

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_idx;
  logic               w_any;
  logic [DATA_W-1:0]  w_sel_a;
  logic [DATA_W-1:0]  w_sel_b;
  logic               w_sel_sub;
  logic               w_ovf;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .i_req   (req_valid),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Operand mux for the current arbitration winner.
  assign w_sel_a   = req_a[32'(w_idx)*DATA_W +: DATA_W];
  assign w_sel_b   = req_b[32'(w_idx)*DATA_W +: DATA_W];
  assign w_sel_sub = req_sub[w_idx];

  // Adder is configured from the operand registers; meaningful only in EXEC.
  assign adder_a   = r_op_a;
  assign adder_b   = r_op_sub ? ~r_op_b : r_op_b;
  assign adder_cin = r_op_sub;
  assign w_ovf     = signed_ovf(r_op_a[DATA_W-1], adder_b[DATA_W-1], adder_sum[DATA_W-1]);

  // Accept strobe only while idle, same cycle as the request.
  assign req_ready = (r_state == ST_IDLE) ? w_grant : '0;

  // Response channel driven straight from state and result registers.
  assign resp_valid = (r_state == ST_RESP);
  assign resp_id    = r_id;
  assign resp_sum   = r_sum;
  assign resp_cout  = r_cout;
  assign resp_ovf   = r_ovf;

  // Sequencer: grant/latch in IDLE, capture in EXEC, hold result in RESP.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_last   <= ID_W'(NUM_REQ - 1);
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_op_sub <= 1'b0;
      r_id     <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_op_a   <= w_sel_a;
            r_op_b   <= w_sel_b;
            r_op_sub <= w_sel_sub;
            r_id     <= w_idx;
            r_last   <= w_idx;
            r_state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_sum   <= adder_sum;
          r_cout  <= adder_cout;
          r_ovf   <= w_ovf;
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Directed bench for adder_share_ctrl with a behavioural shared adder.
module tb_adder_share_ctrl;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;

  logic                  clock = 1'b0;
  logic                  reset_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]    req_sub;
  logic [31:0]           adder_a;
  logic [31:0]           adder_b;
  logic                  adder_cin;
  logic [31:0]           adder_sum;
  logic                  adder_cout;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic [31:0]           resp_sum;
  logic                  resp_cout;
  logic                  resp_ovf;

  int n_cmp = 0;
  int n_err = 0;

  adder_share_ctrl #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_sub    (req_sub),
    .adder_a    (adder_a),
    .adder_b    (adder_b),
    .adder_cin  (adder_cin),
    .adder_sum  (adder_sum),
    .adder_cout (adder_cout),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum),
    .resp_cout  (resp_cout),
    .resp_ovf   (resp_ovf)
  );

  // External shared adder.
  assign {adder_cout, adder_sum} = 33'(adder_a) + 33'(adder_b) + 33'(adder_cin);

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_sub[i]        = s;
    req_valid[i]      = 1'b1;
  endtask

  // One lone request with resp_ready high; starts and ends at an IDLE negedge.
  task automatic do_op(input string tag, input int i, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [31:0] e_sum, input logic e_cout, input logic e_ovf);
    set_req(i, a, b, s);
    #1 chk({tag, "_ready"}, 32'(req_ready), 32'(1) << i);
    @(negedge clock);
    req_valid = '0;
    chk({tag, "_exec_valid"}, 32'(resp_valid), 32'd0);
    @(negedge clock);
    chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, "_sum"},   resp_sum, e_sum);
    chk({tag, "_cout"},  32'(resp_cout), 32'(e_cout));
    chk({tag, "_ovf"},   32'(resp_ovf), 32'(e_ovf));
    chk({tag, "_id"},    32'(resp_id), 32'(i));
    @(negedge clock);
    chk({tag, "_done"},  32'(resp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    reset_n    = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_sub    = '0;
    resp_ready = 1'b1;

    // Reset state
    @(negedge clock);
    @(negedge clock);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_adder_a", adder_a, 32'd0);
    chk("rst_adder_b", adder_b, 32'd0);
    chk("rst_cin", 32'(adder_cin), 32'd0);
    chk("rst_sum", resp_sum, 32'd0);
    chk("rst_id", 32'(resp_id), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("idle_ready", 32'(req_ready), 32'd0);
    chk("idle_valid", 32'(resp_valid), 32'd0);

    // Basic add, signed overflow, subtract with borrow
    do_op("add5_3", 0, 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0);
    do_op("ovf_add", 2, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    do_op("sub3_5", 1, 32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);

    // Back-pressure: result held while requester 3 waits
    resp_ready = 1'b0;
    set_req(0, 32'd10, 32'd20, 1'b0);
    #1 chk("bp_ready0", 32'(req_ready), 32'h1);
    @(negedge clock);
    req_valid = '0;
    set_req(3, 32'd100, 32'd1, 1'b1);
    chk("bp_exec_ready", 32'(req_ready), 32'd0);
    @(negedge clock);
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_valid", 32'(resp_valid), 32'd1);
      chk("bp_hold_sum", resp_sum, 32'd30);
      chk("bp_hold_id", 32'(resp_id), 32'd0);
      chk("bp_hold_ready", 32'(req_ready), 32'd0);
      @(negedge clock);
    end
    resp_ready = 1'b1;
    @(negedge clock);
    chk("bp_grant3", 32'(req_ready), 32'h8);
    chk("bp_released", 32'(resp_valid), 32'd0);
    @(negedge clock);
    req_valid = '0;
    @(negedge clock);
    chk("bp3_sum", resp_sum, 32'd99);
    chk("bp3_cout", 32'(resp_cout), 32'd1);
    chk("bp3_ovf", 32'(resp_ovf), 32'd0);
    chk("bp3_id", 32'(resp_id), 32'd3);
    @(negedge clock);

    // Asynchronous reset during EXEC
    set_req(0, 32'd1, 32'd1, 1'b0);
    #1 chk("ar_ready", 32'(req_ready), 32'h1);
    @(negedge clock);
    req_valid = '0;
    chk("ar_exec_a", adder_a, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_valid", 32'(resp_valid), 32'd0);
    chk("ar_ready0", 32'(req_ready), 32'd0);
    chk("ar_adder_a", adder_a, 32'd0);
    chk("ar_adder_b", adder_b, 32'd0);
    chk("ar_sum", resp_sum, 32'd0);
    chk("ar_cout", 32'(resp_cout), 32'd0);
    chk("ar_id", 32'(resp_id), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // All requesters held valid: rotation 0,1,2,3,0, one grant per 3 cycles
    for (int i = 0; i < 4; i++) set_req(i, 32'h100 * (i + 1), 32'(i), 1'b0);
    for (int g = 0; g < 5; g++) begin
      int exp_id;
      exp_id = g % 4;
      #1 chk("rr_ready", 32'(req_ready), 32'(1) << exp_id);
      @(negedge clock);
      chk("rr_exec_valid", 32'(resp_valid), 32'd0);
      @(negedge clock);
      chk("rr_valid", 32'(resp_valid), 32'd1);
      chk("rr_id", 32'(resp_id), 32'(exp_id));
      chk("rr_sum", resp_sum, 32'h100 * (exp_id + 1) + 32'(exp_id));
      @(negedge clock);
    end
    req_valid = '0;

    // Equal operands subtract: no borrow
    do_op("subff", 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
